mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning consecutive data grants allowed while an instruction request waits (fairness build only).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_req  input  1  instruction-fetch request; held high until i_ack.
REQ-005 SHALL have port i_addr_in  input  16  fetch address; stable while i_req is high.
REQ-006 SHALL have port i_ack  output  1  one-cycle pulse: fetch word valid on d_bus this cycle.
REQ-007 SHALL have port d_req  input  1  data request; held high until d_ack.
REQ-008 SHALL have port d_we  input  1  1 = write, 0 = read; stable while d_req is high.
REQ-009 SHALL have port d_addr_in  input  16  data address; stable while d_req is high.
REQ-010 SHALL have port d_ack  output  1  one-cycle pulse: write captured, or read word valid on d_bus.
REQ-011 SHALL have ports mem_d_read, mem_d_write, mem_d_push, mem_i_read, mem_i_push  output  1 each  memory control strobes.
REQ-012 SHALL have ports mem_d_addr, mem_i_addr  output  16 each  memory addresses.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, PUSH; all outputs registered.
REQ-015 In IDLE, on an edge with any request high, SHALL grant one requester, latch its address/we, and enter ACCESS; with no request, SHALL stay in IDLE.
REQ-016 Default arbitration: when d_req and i_req are both high, data wins.
REQ-017 ACCESS, data read: mem_d_read=1, mem_d_addr=latched addr; next state PUSH.
REQ-018 ACCESS, data write: mem_d_write=1, d_ack=1, requester drives d_bus this cycle; next state IDLE.
REQ-019 ACCESS, fetch: mem_i_read=1, mem_i_addr=latched addr; next state PUSH.
REQ-020 PUSH: mem_d_push with d_ack, or mem_i_push with i_ack, per the granted requester; next state IDLE.
REQ-021 Read latency: request sampled at edge N -> ack during cycle N+2; write: ack during cycle N+1.
REQ-022 At most one memory strobe and at most one ack high in any cycle; push never concurrent with write.
REQ-023 Address outputs SHALL hold the latched value from ACCESS through PUSH; unused address output holds its last value.
REQ-024 Request deasserted mid-transaction SHALL be ignored; transaction completes.
REQ-025 Minimum one IDLE cycle between transactions.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, every strobe, ack and busy to 0, addresses to 16'h0000, starvation counter to 0.
REQ-027 Reset mid-transaction SHALL drop the transaction with no ack; requester reissues.
REQ-028 First grant possible on the first rising edge after rst_n rises.

Configuration
REQ-029 Macro MEM_ARBITER_FAIRNESS_EN defined: a 3-bit-minimum counter SHALL increment on each data grant while i_req is high, clear on every fetch grant, and force a fetch grant when it equals STARVE_MAX.
REQ-030 Macro undefined: no counter; strict data-over-instruction priority per REQ-016.

Verification
REQ-031 Fetch i_addr_in=0x0010, memory word 0xBF01 -> mem_i_read in cycle N+1, mem_i_push and i_ack in N+2, d_bus=0xBF01.
REQ-032 Data write 0x1234 to 0x0120, then read 0x0120 -> d_ack in N+1 for write; read returns 0x1234 with d_ack two cycles after its grant.
REQ-033 d_req (read) and i_req simultaneous -> data served first, fetch granted on the edge after the data PUSH cycle; never two strobes concurrent.
REQ-034 rst_n low during PUSH -> all outputs 0 within the same cycle, no ack; retried fetch completes normally.
REQ-035 Fairness build, d_req held high continuously with i_req high -> fetch granted after exactly 4 data grants; non-fairness build -> fetch never granted.

Source files
------------

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Two-requester memory arbiter: instruction fetch and data read/write share one memory port.
// Define MEM_ARBITER_FAIRNESS_EN to bound how long a waiting fetch can be starved by data traffic.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr_in,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr_in,
  output logic        d_ack,
  output logic        mem_d_read,
  output logic        mem_d_write,
  output logic        mem_d_push,
  output logic        mem_i_read,
  output logic        mem_i_push,
  output logic [15:0] mem_d_addr,
  output logic [15:0] mem_i_addr,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    PUSH   = 2'd2
  } state_t;

  state_t      state_r;
  logic        gnt_d_r;
  logic        we_r;
  logic        i_ack_r, d_ack_r;
  logic        mem_d_read_r, mem_d_write_r, mem_d_push_r;
  logic        mem_i_read_r, mem_i_push_r;
  logic [15:0] mem_d_addr_r, mem_i_addr_r;
  logic        busy_r;
  logic        grant_d_s, grant_i_s;
  logic        starved_s;

`ifdef MEM_ARBITER_FAIRNESS_EN
  localparam int CNT_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

  logic [CNT_W-1:0] starve_cnt_r;

  // A waiting fetch is forced through once data has won STARVE_MAX times in a row.
  always_comb begin
    starved_s = i_req && (starve_cnt_r == CNT_W'(STARVE_MAX));
  end

  // Counts data grants taken while a fetch was pending; any fetch grant clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (grant_i_s) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (grant_d_s && i_req) begin
      starve_cnt_r <= starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  // Strict data priority: STARVE_MAX is only meaningful in the fairness build.
  always_comb begin
    starved_s = (STARVE_MAX < 0);
  end
`endif

  // Grant decision, only taken while IDLE; data wins unless the fetch is starved.
  always_comb begin
    grant_d_s = 1'b0;
    grant_i_s = 1'b0;
    if (state_r == IDLE) begin
      if (d_req && !starved_s) begin
        grant_d_s = 1'b1;
      end else if (i_req) begin
        grant_i_s = 1'b1;
      end else begin
        grant_i_s = 1'b0;
      end
    end else begin
      grant_d_s = 1'b0;
    end
  end

  // Transaction FSM; strobes are registered one cycle ahead so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      gnt_d_r       <= 1'b0;
      we_r          <= 1'b0;
      i_ack_r       <= 1'b0;
      d_ack_r       <= 1'b0;
      mem_d_read_r  <= 1'b0;
      mem_d_write_r <= 1'b0;
      mem_d_push_r  <= 1'b0;
      mem_i_read_r  <= 1'b0;
      mem_i_push_r  <= 1'b0;
      mem_d_addr_r  <= 16'h0000;
      mem_i_addr_r  <= 16'h0000;
      busy_r        <= 1'b0;
    end else begin
      i_ack_r       <= 1'b0;
      d_ack_r       <= 1'b0;
      mem_d_read_r  <= 1'b0;
      mem_d_write_r <= 1'b0;
      mem_d_push_r  <= 1'b0;
      mem_i_read_r  <= 1'b0;
      mem_i_push_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_d_s) begin
            state_r      <= ACCESS;
            busy_r       <= 1'b1;
            gnt_d_r      <= 1'b1;
            we_r         <= d_we;
            mem_d_addr_r <= d_addr_in;
            if (d_we) begin
              mem_d_write_r <= 1'b1;
              d_ack_r       <= 1'b1;
            end else begin
              mem_d_read_r  <= 1'b1;
            end
          end else if (grant_i_s) begin
            state_r      <= ACCESS;
            busy_r       <= 1'b1;
            gnt_d_r      <= 1'b0;
            we_r         <= 1'b0;
            mem_i_addr_r <= i_addr_in;
            mem_i_read_r <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        ACCESS: begin
          if (gnt_d_r && we_r) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (gnt_d_r) begin
            state_r      <= PUSH;
            busy_r       <= 1'b1;
            mem_d_push_r <= 1'b1;
            d_ack_r      <= 1'b1;
          end else begin
            state_r      <= PUSH;
            busy_r       <= 1'b1;
            mem_i_push_r <= 1'b1;
            i_ack_r      <= 1'b1;
          end
        end
        PUSH: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign i_ack       = i_ack_r;
  assign d_ack       = d_ack_r;
  assign mem_d_read  = mem_d_read_r;
  assign mem_d_write = mem_d_write_r;
  assign mem_d_push  = mem_d_push_r;
  assign mem_i_read  = mem_i_read_r;
  assign mem_i_push  = mem_i_push_r;
  assign mem_d_addr  = mem_d_addr_r;
  assign mem_i_addr  = mem_i_addr_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mem_arbiter with a tiny memory model driving the shared data bus.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr_in, d_addr_in, wdata;
  logic        i_ack, d_ack;
  logic        mem_d_read, mem_d_write, mem_d_push, mem_i_read, mem_i_push;
  logic [15:0] mem_d_addr, mem_i_addr;
  logic        busy;
  logic [15:0] d_bus;
  logic [15:0] dmem [0:255];
  logic [7:0]  ctl;

  int n_assert = 0;
  int n_fail   = 0;
  int d_cnt, d_before_fetch, fetch_seen;

  // {busy, d_read, d_write, d_push, i_read, i_push, d_ack, i_ack}
  localparam logic [7:0] C_IDLE = 8'b0000_0000;
  localparam logic [7:0] C_IRD  = 8'b1000_1000;
  localparam logic [7:0] C_IPS  = 8'b1000_0101;
  localparam logic [7:0] C_DRD  = 8'b1100_0000;
  localparam logic [7:0] C_DWR  = 8'b1010_0010;
  localparam logic [7:0] C_DPS  = 8'b1001_0010;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (i_req),
    .i_addr_in   (i_addr_in),
    .i_ack       (i_ack),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr_in   (d_addr_in),
    .d_ack       (d_ack),
    .mem_d_read  (mem_d_read),
    .mem_d_write (mem_d_write),
    .mem_d_push  (mem_d_push),
    .mem_i_read  (mem_i_read),
    .mem_i_push  (mem_i_push),
    .mem_d_addr  (mem_d_addr),
    .mem_i_addr  (mem_i_addr),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ctl = {busy, mem_d_read, mem_d_write, mem_d_push, mem_i_read, mem_i_push, d_ack, i_ack};

  // Instruction ROM holds one word; data RAM is written by the write strobe.
  always_comb begin
    if (mem_i_push)       d_bus = (mem_i_addr == 16'h0010) ? 16'hBF01 : 16'h0000;
    else if (mem_d_push)  d_bus = dmem[mem_d_addr[7:0]];
    else if (mem_d_write) d_bus = wdata;
    else                  d_bus = 16'h0000;
  end

  always @(posedge clk) begin
    if (mem_d_write) dmem[mem_d_addr[7:0]] <= d_bus;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr_in = 16'h0000; d_addr_in = 16'h0000; wdata = 16'h0000;
    #1;
    chk("reset_ctl", {24'd0, ctl}, {24'd0, C_IDLE});
    chk("reset_addrs", {mem_d_addr, mem_i_addr}, 32'h0000_0000);

    // Fetch issued together with reset release: granted on the first edge.
    @(negedge clk); rst_n = 1'b1; i_req = 1'b1; i_addr_in = 16'h0010;
    @(negedge clk);
    chk("fetch_access", {24'd0, ctl}, {24'd0, C_IRD});
    chk("fetch_addr", {16'd0, mem_i_addr}, 32'h0000_0010);
    @(negedge clk);
    chk("fetch_push", {24'd0, ctl}, {24'd0, C_IPS});
    chk("fetch_data", {16'd0, d_bus}, 32'h0000_BF01);
    i_req = 1'b0;
    @(negedge clk);
    chk("fetch_idle", {24'd0, ctl}, {24'd0, C_IDLE});

    // Data write then read back.
    d_req = 1'b1; d_we = 1'b1; d_addr_in = 16'h0120; wdata = 16'h1234;
    @(negedge clk);
    chk("write_access", {24'd0, ctl}, {24'd0, C_DWR});
    chk("write_addr", {16'd0, mem_d_addr}, 32'h0000_0120);
    d_req = 1'b0;
    @(negedge clk);
    chk("write_idle", {24'd0, ctl}, {24'd0, C_IDLE});
    chk("i_addr_hold", {16'd0, mem_i_addr}, 32'h0000_0010);
    d_req = 1'b1; d_we = 1'b0;
    @(negedge clk);
    chk("read_access", {24'd0, ctl}, {24'd0, C_DRD});
    @(negedge clk);
    chk("read_push", {24'd0, ctl}, {24'd0, C_DPS});
    chk("read_data", {16'd0, d_bus}, 32'h0000_1234);
    d_req = 1'b0;
    @(negedge clk);
    chk("read_idle", {24'd0, ctl}, {24'd0, C_IDLE});

    // Simultaneous requests: data first, fetch after one idle cycle.
    d_req = 1'b1; i_req = 1'b1;
    @(negedge clk);
    chk("sim_d_access", {24'd0, ctl}, {24'd0, C_DRD});
    @(negedge clk);
    chk("sim_d_push", {24'd0, ctl}, {24'd0, C_DPS});
    d_req = 1'b0;
    @(negedge clk);
    chk("sim_idle_gap", {24'd0, ctl}, {24'd0, C_IDLE});
    @(negedge clk);
    chk("sim_i_access", {24'd0, ctl}, {24'd0, C_IRD});
    @(negedge clk);
    chk("sim_i_push", {24'd0, ctl}, {24'd0, C_IPS});
    i_req = 1'b0;
    @(negedge clk);
    chk("sim_idle_end", {24'd0, ctl}, {24'd0, C_IDLE});

    // Request dropped right after grant: transaction still completes.
    d_req = 1'b1;
    @(negedge clk);
    chk("drop_access", {24'd0, ctl}, {24'd0, C_DRD});
    d_req = 1'b0;
    @(negedge clk);
    chk("drop_push", {24'd0, ctl}, {24'd0, C_DPS});
    @(negedge clk);
    chk("drop_idle", {24'd0, ctl}, {24'd0, C_IDLE});

    // Reset asserted in the PUSH cycle of a fetch; fetch is retried.
    i_req = 1'b1;
    @(negedge clk);
    chk("rst_fetch_access", {24'd0, ctl}, {24'd0, C_IRD});
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_push_ctl", {24'd0, ctl}, {24'd0, C_IDLE});
    chk("rst_push_addrs", {mem_d_addr, mem_i_addr}, 32'h0000_0000);
    @(negedge clk);
    chk("rst_held_ctl", {24'd0, ctl}, {24'd0, C_IDLE});
    rst_n = 1'b1;
    @(negedge clk);
    chk("retry_access", {24'd0, ctl}, {24'd0, C_IRD});
    @(negedge clk);
    chk("retry_push", {24'd0, ctl}, {24'd0, C_IPS});
    chk("retry_data", {16'd0, d_bus}, 32'h0000_BF01);
    i_req = 1'b0;
    @(negedge clk);
    chk("retry_idle", {24'd0, ctl}, {24'd0, C_IDLE});

    // Continuous data reads with a pending fetch.
    d_req = 1'b1; d_we = 1'b0; i_req = 1'b1;
    d_cnt = 0; d_before_fetch = -1; fetch_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("one_strobe", {31'd0, ($countones({mem_d_read, mem_d_write, mem_d_push, mem_i_read, mem_i_push}) <= 1)}, 32'd1);
      chk("one_ack", {31'd0, !(d_ack && i_ack)}, 32'd1);
      if (mem_d_read) d_cnt++;
      if (mem_i_read && (fetch_seen == 0)) begin
        fetch_seen = 1;
        d_before_fetch = d_cnt;
      end
      if (i_ack) i_req = 1'b0;
    end
`ifdef MEM_ARBITER_FAIRNESS_EN
    chk("fair_fetch_seen", fetch_seen, 32'd1);
    chk("fair_d_before_fetch", d_before_fetch, 32'd4);
`else
    chk("strict_no_fetch", fetch_seen, 32'd0);
    chk("strict_d_count", d_cnt, 32'd10);
`endif
    d_req = 1'b0; i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("final_idle", {24'd0, ctl}, {24'd0, C_IDLE});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
